// File: rtl/risc16_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : risc16_seq_pkg
// Brief   : Shared types for the RiSC-16 multicycle control sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package risc16_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_ALU    = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_NAND   = 2'b01,
    ALU_PASS_B = 2'b10,
    ALU_LUI    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC1 = 2'b10
  } rf_wsel_e;

  localparam logic [2:0] c_REG_ZERO = 3'd0;

  function automatic opcode_e opcode_of(input logic [15:0] instr);
    return opcode_e'(instr[15:13]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc16_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : risc16_seq_if
// Brief   : Memory handshake and datapath control bundle of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface risc16_seq_if;

  logic                          mem_ack;
  logic [15:0]                   instr;
  logic                          eq;

  logic                          mem_req;
  logic                          mem_we;
  logic                          mem_asel;
  logic [15:0]                   ir;
  logic                          pc_en;
  risc16_seq_pkg::pc_sel_e       pc_sel;
  risc16_seq_pkg::alu_op_e       alu_op;
  logic                          alu_bsel;
  logic                          rf_we;
  risc16_seq_pkg::rf_wsel_e      rf_wsel;
  logic                          halted;
  logic                          err;

  modport master (
    input  mem_ack, instr, eq,
    output mem_req, mem_we, mem_asel, ir, pc_en, pc_sel,
           alu_op, alu_bsel, rf_we, rf_wsel, halted, err
  );

  modport slave (
    output mem_ack, instr, eq,
    input  mem_req, mem_we, mem_asel, ir, pc_en, pc_sel,
           alu_op, alu_bsel, rf_we, rf_wsel, halted, err
  );

endinterface
`default_nettype wire

// File: rtl/risc16_decode.sv
`default_nettype none
// ============================================================================
// Module  : risc16_decode
// Brief   : Combinational instruction-field decode for the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module risc16_decode
  import risc16_seq_pkg::*;
(
  input  opcode_e     i_opcode,
  input  logic [2:0]  i_dest,
  input  logic [6:0]  i_imm7,
  output alu_op_e     o_alu_op,
  output logic        o_alu_bsel,
  output rf_wsel_e    o_rf_wsel,
  output logic        o_rf_wr,
  output logic        o_is_mem,
  output logic        o_is_store,
  output logic        o_is_beq,
  output logic        o_is_jalr,
  output logic        o_is_halt
);

  always_comb begin
    o_alu_op   = ALU_ADD;
    o_alu_bsel = 1'b0;
    o_rf_wsel  = WB_ALU;
    o_rf_wr    = 1'b0;
    o_is_mem   = 1'b0;
    o_is_store = 1'b0;
    o_is_beq   = 1'b0;
    o_is_jalr  = 1'b0;
    o_is_halt  = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_rf_wr = 1'b1;
      end
      OP_ADDI: begin
        o_alu_bsel = 1'b1;
        o_rf_wr    = 1'b1;
      end
      OP_NAND: begin
        o_alu_op = ALU_NAND;
        o_rf_wr  = 1'b1;
      end
      OP_LUI: begin
        o_alu_op = ALU_LUI;
        o_rf_wr  = 1'b1;
      end
      OP_SW: begin
        o_alu_bsel = 1'b1;
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
      end
      OP_LW: begin
        o_alu_bsel = 1'b1;
        o_is_mem   = 1'b1;
        o_rf_wr    = 1'b1;
        o_rf_wsel  = WB_MEM;
      end
      OP_BEQ: begin
        o_is_beq = 1'b1;
      end
      OP_JALR: begin
        o_alu_op  = ALU_PASS_B;
        o_is_jalr = 1'b1;
        // A JALR carrying a nonzero immediate is the HALT encoding.
        if (i_imm7 != 7'd0) begin
          o_is_halt = 1'b1;
        end else begin
          o_rf_wr   = 1'b1;
          o_rf_wsel = WB_PC1;
        end
      end
      default: begin
        o_rf_wr = 1'b0;
      end
    endcase
    if (i_dest == c_REG_ZERO) begin
      o_rf_wr = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/risc16_seq.sv
`default_nettype none
// ============================================================================
// Module  : risc16_seq
// Brief   : Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for RiSC-16.
// Revision: 1.0 - initial release
// ============================================================================
module risc16_seq
  import risc16_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  risc16_seq_if.master       bus
);

  localparam int                  c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  state_e              state_q,    state_d;
  logic [15:0]         ir_q,       ir_d;
  logic [c_WAIT_W-1:0] wait_q,     wait_d;
  logic                halted_q,   halted_d;
  logic                err_q,      err_d;
  logic                mem_req_q,  mem_req_d;
  logic                mem_we_q,   mem_we_d;
  logic                mem_asel_q, mem_asel_d;
  logic                pc_en_q,    pc_en_d;
  pc_sel_e             pc_sel_q,   pc_sel_d;
  alu_op_e             alu_op_q,   alu_op_d;
  logic                alu_bsel_q, alu_bsel_d;
  logic                rf_we_q,    rf_we_d;
  rf_wsel_e            rf_wsel_q,  rf_wsel_d;

  alu_op_e             w_alu_op;
  logic                w_alu_bsel;
  rf_wsel_e            w_rf_wsel;
  logic                w_rf_wr;
  logic                w_is_mem;
  logic                w_is_store;
  logic                w_is_beq;
  logic                w_is_jalr;
  logic                w_is_halt;

  risc16_decode u_decode (
    .i_opcode   (opcode_of(ir_q)),
    .i_dest     (ir_q[12:10]),
    .i_imm7     (ir_q[6:0]),
    .o_alu_op   (w_alu_op),
    .o_alu_bsel (w_alu_bsel),
    .o_rf_wsel  (w_rf_wsel),
    .o_rf_wr    (w_rf_wr),
    .o_is_mem   (w_is_mem),
    .o_is_store (w_is_store),
    .o_is_beq   (w_is_beq),
    .o_is_jalr  (w_is_jalr),
    .o_is_halt  (w_is_halt)
  );

  // Next state and bookkeeping.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    err_d    = err_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        // An ack only counts while our own request is on the bus, so an ack
        // for an access killed by reset never reaches the state machine.
        if (mem_req_q) begin
          if (bus.mem_ack) begin
            if (state_q == S_FETCH) begin
              ir_d    = bus.instr;
              state_d = S_DECODE;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_q == c_WAIT_LAST) begin
            state_d = S_ERROR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = w_is_mem ? S_MEM : S_WB;
      S_WB:     state_d = w_is_halt ? S_HALT : S_FETCH;
      default:  state_d = state_q;
    endcase
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end
    if (state_d == S_HALT) begin
      halted_d = 1'b1;
    end
    if (state_d == S_ERROR) begin
      err_d = 1'b1;
    end
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    mem_req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_asel_d = (state_d == S_MEM);
    mem_we_d   = (state_d == S_MEM) && w_is_store;
    alu_op_d   = ALU_ADD;
    alu_bsel_d = 1'b0;
    pc_en_d    = 1'b0;
    pc_sel_d   = PC_INC;
    rf_we_d    = 1'b0;
    rf_wsel_d  = WB_ALU;
    if (state_d == S_EXEC) begin
      alu_op_d   = w_alu_op;
      alu_bsel_d = w_alu_bsel;
    end
    if (state_d == S_WB) begin
      pc_en_d   = !w_is_halt;
      rf_we_d   = w_rf_wr;
      rf_wsel_d = w_rf_wsel;
      // BEQ always enters WB straight from EXEC, so eq is sampled right here.
      if (w_is_jalr && !w_is_halt) begin
        pc_sel_d = PC_ALU;
      end else if (w_is_beq && bus.eq) begin
        pc_sel_d = PC_BRANCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      wait_q     <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_asel_q <= 1'b0;
      pc_en_q    <= 1'b0;
      pc_sel_q   <= PC_INC;
      alu_op_q   <= ALU_ADD;
      alu_bsel_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wsel_q  <= WB_ALU;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      wait_q     <= wait_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_asel_q <= mem_asel_d;
      pc_en_q    <= pc_en_d;
      pc_sel_q   <= pc_sel_d;
      alu_op_q   <= alu_op_d;
      alu_bsel_q <= alu_bsel_d;
      rf_we_q    <= rf_we_d;
      rf_wsel_q  <= rf_wsel_d;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_asel = mem_asel_q;
  assign bus.ir       = ir_q;
  assign bus.pc_en    = pc_en_q;
  assign bus.pc_sel   = pc_sel_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.alu_bsel = alu_bsel_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_wsel  = rf_wsel_q;
  assign bus.halted   = halted_q;
  assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_risc16_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc16_seq
// Brief   : Self-checking bench for risc16_seq against a per-cycle timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_risc16_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  risc16_seq_if bus ();

  risc16_seq #(.TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.mem_ack = 1'($urandom);
    bus.instr   = 16'($urandom);
    bus.eq      = 1'($urandom);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
    drive_idle();
    step();
  endtask

  // Drives one instruction from its first FETCH cycle through WB. The model
  // lays out the expected timeline: FETCH fd+1, DECODE 1, EXEC 1,
  // MEM md+1 (LW/SW only), WB 1, and the outputs each phase must show.
  task automatic run_instr(input logic [15:0] ins, input int fd, input int md,
                           input int eq_force);
    int op, f_len, m_len, e_idx, w_idx, total;
    bit halt, is_mem, writes, eq_x, in_f, in_m, in_e, in_w;
    logic [1:0] e_op, e_psel, e_wsel;
    logic e_req, e_asel, e_we, e_bsel, e_pcen, e_rfwe;
    op     = int'(ins[15:13]);
    halt   = (op == 7) && (ins[6:0] != 7'd0);
    is_mem = (op == 4) || (op == 5);
    writes = (op != 4) && (op != 6) && !halt && (ins[12:10] != 3'd0);
    f_len  = fd + 1;
    e_idx  = f_len + 1;
    m_len  = is_mem ? md + 1 : 0;
    w_idx  = e_idx + 1 + m_len;
    total  = w_idx + 1;
    eq_x   = 1'b0;
    for (int k = 0; k < total; k++) begin
      in_f = (k < f_len);
      in_e = (k == e_idx);
      in_m = (k > e_idx) && (k < w_idx);
      in_w = (k == w_idx);
      drive_idle();
      if (in_f) begin
        bus.mem_ack = (k == fd);
        if (k == fd) bus.instr = ins;
      end
      if (in_m) bus.mem_ack = (k == w_idx - 1);
      if (in_e) begin
        if (eq_force >= 0) bus.eq = eq_force[0];
        eq_x = bus.eq;
      end
      e_req  = in_f || in_m;
      e_asel = in_m;
      e_we   = in_m && (op == 4);
      case (op)
        2:       e_op = 2'b01;
        3:       e_op = 2'b11;
        7:       e_op = 2'b10;
        default: e_op = 2'b00;
      endcase
      if (!in_e) e_op = 2'b00;
      e_bsel = in_e && (op == 1 || op == 4 || op == 5);
      e_pcen = in_w && !halt;
      e_psel = (in_w && !halt && op == 7) ? 2'b10 :
               (in_w && op == 6 && eq_x)  ? 2'b01 : 2'b00;
      e_rfwe = in_w && writes;
      e_wsel = !in_w ? 2'b00 : (op == 5) ? 2'b01 : (op == 7 && !halt) ? 2'b10 : 2'b00;

      n_cmp++;
      if (bus.mem_req !== e_req) begin n_bad++;
        $display("FAIL mem_req ins=%h k=%0d got %b want %b", ins, k, bus.mem_req, e_req); end
      n_cmp++;
      if (bus.mem_asel !== e_asel) begin n_bad++;
        $display("FAIL mem_asel ins=%h k=%0d got %b want %b", ins, k, bus.mem_asel, e_asel); end
      n_cmp++;
      if (bus.mem_we !== e_we) begin n_bad++;
        $display("FAIL mem_we ins=%h k=%0d got %b want %b", ins, k, bus.mem_we, e_we); end
      n_cmp++;
      if (bus.alu_op !== e_op) begin n_bad++;
        $display("FAIL alu_op ins=%h k=%0d got %b want %b", ins, k, bus.alu_op, e_op); end
      if (!(in_e && (op == 3 || op == 6 || op == 7))) begin
        n_cmp++;
        if (bus.alu_bsel !== e_bsel) begin n_bad++;
          $display("FAIL alu_bsel ins=%h k=%0d got %b want %b", ins, k, bus.alu_bsel, e_bsel); end
      end
      n_cmp++;
      if (bus.pc_en !== e_pcen) begin n_bad++;
        $display("FAIL pc_en ins=%h k=%0d got %b want %b", ins, k, bus.pc_en, e_pcen); end
      n_cmp++;
      if (bus.pc_sel !== e_psel) begin n_bad++;
        $display("FAIL pc_sel ins=%h k=%0d got %b want %b", ins, k, bus.pc_sel, e_psel); end
      n_cmp++;
      if (bus.rf_we !== e_rfwe) begin n_bad++;
        $display("FAIL rf_we ins=%h k=%0d got %b want %b", ins, k, bus.rf_we, e_rfwe); end
      if (!(in_w && halt)) begin
        n_cmp++;
        if (bus.rf_wsel !== e_wsel) begin n_bad++;
          $display("FAIL rf_wsel ins=%h k=%0d got %b want %b", ins, k, bus.rf_wsel, e_wsel); end
      end
      n_cmp++;
      if ({bus.halted, bus.err} !== 2'b00) begin n_bad++;
        $display("FAIL sticky ins=%h k=%0d got %b want 00", ins, k, {bus.halted, bus.err}); end
      if (k >= f_len) begin
        n_cmp++;
        if (bus.ir !== ins) begin n_bad++;
          $display("FAIL ir ins=%h k=%0d got %h want %h", ins, k, bus.ir, ins); end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      step();
      n_cmp++;
      if ({bus.mem_req, bus.mem_we, bus.mem_asel, bus.pc_en, bus.rf_we,
           bus.alu_bsel, bus.halted, bus.err} !== 8'h00) begin n_bad++;
        $display("FAIL reset_strobes got %b want 00000000", {bus.mem_req, bus.mem_we,
                 bus.mem_asel, bus.pc_en, bus.rf_we, bus.alu_bsel, bus.halted, bus.err}); end
      n_cmp++;
      if ({bus.pc_sel, bus.alu_op, bus.rf_wsel} !== 6'b0) begin n_bad++;
        $display("FAIL reset_sels got %b want 000000", {bus.pc_sel, bus.alu_op, bus.rf_wsel}); end
      n_cmp++;
      if (bus.ir !== 16'h0000) begin n_bad++;
        $display("FAIL reset_ir got %h want 0000", bus.ir); end
    end
    rst = 1'b0;
    drive_idle();
    step();
    n_cmp++;
    if ({bus.mem_req, bus.mem_asel, bus.mem_we} !== 3'b100) begin n_bad++;
      $display("FAIL post_reset_fetch got %b want 100", {bus.mem_req, bus.mem_asel, bus.mem_we}); end
    n_cmp++;
    if (bus.ir !== 16'h0000) begin n_bad++;
      $display("FAIL post_reset_ir got %h want 0000", bus.ir); end
  endtask

  task automatic test_directed_ops();
    run_instr(16'h0481, 0, 0, -1);   // ADD r1: pc_en in 4th cycle
    run_instr(16'hC47F, 0, 0, 1);    // BEQ taken
    run_instr(16'hC47F, 0, 0, 0);    // BEQ not taken
    run_instr(16'hA402, 0, 3, -1);   // LW with 3 wait cycles in MEM
    run_instr(16'h8402, 2, 1, -1);   // SW with fetch and memory waits
    run_instr(16'hE400, 0, 0, -1);   // JALR r1
    run_instr(16'h0001, 1, 0, -1);   // ADD to r0: write suppressed
    run_instr(16'h6C05, 0, 0, -1);   // LUI r3
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    for (int n = 0; n < 150; n++) begin
      ins = 16'($urandom);
      if (ins[15:13] == 3'd7) ins[6:0] = 7'd0;
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end
  endtask

  task automatic test_halt();
    run_instr(16'hE001, 0, 0, -1);
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({bus.halted, bus.mem_req, bus.pc_en, bus.rf_we, bus.err} !== 5'b10000) begin n_bad++;
        $display("FAIL halt_absorb cyc=%0d got %b want 10000", i,
                 {bus.halted, bus.mem_req, bus.pc_en, bus.rf_we, bus.err}); end
      drive_idle();
      step();
    end
    apply_reset();
    n_cmp++;
    if ({bus.halted, bus.mem_req} !== 2'b01) begin n_bad++;
      $display("FAIL halt_rst_exit got %b want 01", {bus.halted, bus.mem_req}); end
  endtask

  task automatic test_sw_reset();
    apply_reset();
    drive_idle();
    bus.mem_ack = 1'b1;
    bus.instr   = 16'h8402;
    step();                // DECODE
    drive_idle();
    step();                // EXEC
    drive_idle();
    step();                // MEM
    n_cmp++;
    if ({bus.mem_req, bus.mem_asel, bus.mem_we} !== 3'b111) begin n_bad++;
      $display("FAIL sw_mem got %b want 111", {bus.mem_req, bus.mem_asel, bus.mem_we}); end
    bus.mem_ack = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({bus.mem_req, bus.mem_asel, bus.mem_we, bus.pc_en, bus.rf_we} !== 5'b0) begin n_bad++;
      $display("FAIL sw_rst_drop got %b want 00000",
               {bus.mem_req, bus.mem_asel, bus.mem_we, bus.pc_en, bus.rf_we}); end
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.instr   = 16'($urandom);
    step();
    n_cmp++;
    if ({bus.mem_req, bus.mem_asel, bus.mem_we, bus.pc_en, bus.rf_we} !== 5'b10000) begin n_bad++;
      $display("FAIL sw_late_ack got %b want 10000",
               {bus.mem_req, bus.mem_asel, bus.mem_we, bus.pc_en, bus.rf_we}); end
    n_cmp++;
    if (bus.ir !== 16'h0000) begin n_bad++;
      $display("FAIL sw_late_ack_ir got %h want 0000", bus.ir); end
    run_instr(16'h0481, 1, 0, -1);
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      n_cmp++;
      if ({bus.mem_req, bus.err} !== 2'b10) begin n_bad++;
        $display("FAIL timeout_wait cyc=%0d got %b want 10", i, {bus.mem_req, bus.err}); end
      bus.mem_ack = 1'b0;
      bus.instr   = 16'($urandom);
      bus.eq      = 1'($urandom);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bus.err, bus.mem_req, bus.pc_en, bus.halted, bus.rf_we} !== 5'b10000) begin n_bad++;
        $display("FAIL timeout_err cyc=%0d got %b want 10000", i,
                 {bus.err, bus.mem_req, bus.pc_en, bus.halted, bus.rf_we}); end
      n_cmp++;
      if (bus.ir !== 16'h0000) begin n_bad++;
        $display("FAIL timeout_ir cyc=%0d got %h want 0000", i, bus.ir); end
      drive_idle();
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_directed_ops();
    test_back_to_back();
    test_halt();
    test_sw_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc16_seq.md
RISC16_SEQ -- requirements
Module: risc16_seq

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum wait cycles for mem_ack before error.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 instr  in  16  memory read data, valid when mem_ack=1.
REQ-005 mem_ack  in  1  memory completion strobe, one cycle per access.
REQ-006 eq  in  1  ALU equality flag (regA==regB), valid in EXEC.
REQ-007 mem_req  out  1  memory access request, held until ack.
REQ-008 mem_we  out  1  write request (SW only); valid with mem_req.
REQ-009 mem_asel  out  1  address select: 0=PC, 1=ALU result.
REQ-010 ir  out  16  latched instruction register.
REQ-011 pc_en  out  1  one-cycle PC update strobe.
REQ-012 pc_sel  out  2  PC mux select: 00 PC+1, 01 PC+1+sext(imm7), 10 ALU out.
REQ-013 alu_op  out  2  00 add, 01 nand, 10 pass B, 11 lui-pass.
REQ-014 alu_bsel  out  1  ALU B operand: 0=regC, 1=sext imm.
REQ-015 rf_we  out  1  register-file write strobe.
REQ-016 rf_wsel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+1.
REQ-017 halted  out  1  sticky; core stopped by HALT.
REQ-018 err  out  1  sticky; memory timeout occurred.

Function
REQ-019 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
REQ-020 FETCH: mem_req=1, mem_asel=0, mem_we=0; on mem_ack latch instr into ir, go DECODE.
REQ-021 DECODE: one cycle, opcode = ir[15:13]; -> EXEC always.
REQ-022 EXEC: drive alu_op/alu_bsel per opcode (ADD/NAND regC, ADDI/LW/SW imm, LUI lui-pass, JALR pass B, BEQ add-don't-care); sample eq for BEQ; -> MEM for LW/SW, else -> WB.
REQ-023 MEM: mem_req=1, mem_asel=1, mem_we=1 only for SW; on mem_ack -> WB.
REQ-024 WB: pc_en=1 for exactly this cycle; pc_sel=01 if BEQ with sampled eq=1, 10 if JALR, else 00; -> FETCH.
REQ-025 rf_we=1 in WB for ADD, ADDI, NAND, LUI (wsel 00), LW (wsel 01), JALR (wsel 10); 0 for SW, BEQ.
REQ-026 rf_we SHALL be suppressed when destination field ir[12:10]==0.
REQ-027 JALR with ir[6:0]!=0 is HALT: in WB no PC update, no rf write; -> HALT; halted=1.
REQ-028 HALT and ERROR are absorbing; only rst exits.
REQ-029 Wait counter: cleared on entry to FETCH/MEM, increments each cycle without ack; reaching TIMEOUT -> ERROR, err=1, mem_req drops next cycle.
REQ-030 mem_ack in same cycle as first mem_req assertion SHALL be accepted (zero-wait access: FETCH lasts 1 cycle).
REQ-031 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-032 Instruction latency: 4 cycles (non-memory), 5 cycles (LW/SW) with zero-wait memory.
REQ-033 All outputs not named active in a state SHALL be 0 in that state.

Reset
REQ-034 rst=1 SHALL force state FETCH, ir=0, wait counter=0, halted=0, err=0, all strobes 0, on the same edge.
REQ-035 rst mid-MEM or mid-FETCH SHALL drop mem_req the cycle after the edge and discard any later ack for that access.
REQ-036 First cycle after rst deasserts SHALL assert mem_req with mem_asel=0.

Structure
REQ-037 Shared package holds opcode constants, state enum, pc_sel/alu_op/rf_wsel encodings.
REQ-038 One sub-module, risc16_decode: combinational ir -> alu_op, alu_bsel, rf_wsel, write-enable, is_mem, is_halt.

Verification
REQ-039 ADD 0x0000-form instr 0x0481 (r1=r1+r1? dest r1) zero-wait -> pc_en at cycle 4, pc_sel=00, rf_we=1, rf_wsel=00.
REQ-040 BEQ instr 0xC47F, eq=1 -> WB pc_sel=01; same with eq=0 -> pc_sel=00; rf_we=0 both.
REQ-041 LW instr 0xA402, ack delayed 3 cycles in MEM -> mem_asel=1 held 4 cycles, WB rf_wsel=01, total 8 cycles.
REQ-042 JALR 0xE400 -> pc_sel=10, rf_wsel=10; JALR 0xE001 -> halted=1, pc_en never asserted, mem_req stays 0.
REQ-043 No ack for 255 cycles in FETCH -> err=1, state ERROR, mem_req=0 thereafter.
REQ-044 rst asserted during MEM of SW, ack arrives next cycle -> no WB, state FETCH, rf_we=0, pc_en=0.
